// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default timing constants for the servo PWM block.
package pwm_pkg;

    localparam int DUTY_W = 24;

    // 20 ms frame at 50 MHz, 0.4 ms .. 2.4 ms pulse window
    localparam int PERIOD_DEFAULT   = 1000000;
    localparam int DUTY_MIN_DEFAULT = 20000;
    localparam int DUTY_MAX_DEFAULT = 120000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_servo_if.sv
// pwm_servo_if: run request / duty input and waveform status outputs of pwm_servo.
interface pwm_servo_if;

    logic                           enable;
    logic [pwm_pkg::DUTY_W-1:0]     duty;
    logic                           pwm_out;
    logic                           period_start;
    logic [pwm_pkg::DUTY_W-1:0]     duty_active;
    logic                           busy;

    modport master (
        output enable, duty,
        input  pwm_out, period_start, duty_active, busy
    );

    modport slave (
        input  enable, duty,
        output pwm_out, period_start, duty_active, busy
    );

endinterface

// File: rtl/duty_clamp.sv
// duty_clamp: combinational limiter forcing a requested high-time into [DUTY_MIN, DUTY_MAX].
module duty_clamp
    import pwm_pkg::*;
#(
    parameter int DUTY_MIN = DUTY_MIN_DEFAULT,
    parameter int DUTY_MAX = DUTY_MAX_DEFAULT
) (
    input  logic [DUTY_W-1:0] duty_in,
    output logic [DUTY_W-1:0] duty_out
);

    localparam logic [DUTY_W-1:0] LO = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] HI = DUTY_W'(DUTY_MAX);

    // saturate to the nearest window edge, pass through otherwise
    always_comb begin
        duty_out = duty_in;
        if (duty_in < LO) begin
            duty_out = LO;
        end else if (duty_in > HI) begin
            duty_out = HI;
        end
    end

endmodule

// File: rtl/pwm_servo.sv
// pwm_servo: frame-based servo PWM generator (IDLE/HIGH/LOW FSM with cycle counter).
// Optional feature macro: PWM_CLAMP_EN -- clamps the sampled duty into
// [DUTY_MIN, DUTY_MAX] through duty_clamp before it is latched.
module pwm_servo
    import pwm_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEFAULT,
    parameter int DUTY_MIN = DUTY_MIN_DEFAULT,
    parameter int DUTY_MAX = DUTY_MAX_DEFAULT
) (
    input  logic         clk_in,
    input  logic         rst_n,
    pwm_servo_if.slave   bus
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] ONE  = DUTY_W'(1);

    // parameter sanity: counter must hold PERIOD-1 and the clamp window must be ordered
    if (PERIOD < 2 || PERIOD > (1 << DUTY_W) || DUTY_MIN > DUTY_MAX) begin : g_bad_cfg
        $error("pwm_servo: invalid PERIOD/DUTY_MIN/DUTY_MAX");
    end

    state_t             state, state_next;
    logic [DUTY_W-1:0]  cnt, cnt_next;
    logic [DUTY_W-1:0]  duty_next;
    logic [DUTY_W-1:0]  duty_sel;
    logic               start_next;
    logic               boundary;

`ifdef PWM_CLAMP_EN
    duty_clamp #(
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX)
    ) u_duty_clamp (
        .duty_in  (bus.duty),
        .duty_out (duty_sel)
    );
`else
    assign duty_sel = bus.duty;
`endif

    assign boundary = (state != IDLE) && (cnt == LAST);

    // next-state: a period starts from IDLE or at the frame boundary; the
    // boundary has priority so an over-long duty keeps pwm high without a gap
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        duty_next  = bus.duty_active;
        start_next = 1'b0;
        if (state == IDLE || boundary) begin
            if (bus.enable) begin
                start_next = 1'b1;
                duty_next  = duty_sel;
                cnt_next   = '0;
                state_next = (duty_sel == '0) ? LOW : HIGH;
            end else if (boundary) begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        end else begin
            cnt_next = cnt + ONE;
            if (state == HIGH && cnt == bus.duty_active - ONE) begin
                state_next = LOW;
            end
        end
    end

    // state, counter and registered outputs; pwm_out follows the next state so
    // it rises together with period_start
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.pwm_out      <= 1'b0;
            bus.period_start <= 1'b0;
            bus.duty_active  <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            bus.pwm_out      <= (state_next == HIGH);
            bus.period_start <= start_next;
            bus.duty_active  <= duty_next;
        end
    end

    // busy mirrors any non-IDLE state
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_servo.sv
// tb_pwm_servo: randomized and directed stimulus for pwm_servo (PERIOD=100,
// DUTY_MIN=10, DUTY_MAX=60) compared cycle by cycle against a frame-position model.
// Build with or without PWM_CLAMP_EN, matching the RTL build.
module tb_pwm_servo;

    localparam int P    = 100;
    localparam int DMIN = 10;
    localparam int DMAX = 60;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    pwm_servo_if bus ();

    pwm_servo #(
        .PERIOD   (P),
        .DUTY_MIN (DMIN),
        .DUTY_MAX (DMAX)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: running flag, position within the frame, latched high-time
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_duty = 0;

    function automatic int eff_duty(int d);
`ifdef PWM_CLAMP_EN
        if (d < DMIN) return DMIN;
        if (d > DMAX) return DMAX;
`endif
        return d;
    endfunction

    function automatic int exp_high(int d);
        int e;
        e = eff_duty(d);
        return (e > P) ? P : e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_run = 1'b0; m_pos = 0; m_duty = 0;
        end else if (!m_run) begin
            if (bus.enable) begin
                m_run = 1'b1; m_pos = 0; m_duty = eff_duty(int'(bus.duty));
            end
        end else if (m_pos == P - 1) begin
            if (bus.enable) begin
                m_pos = 0; m_duty = eff_duty(int'(bus.duty));
            end else begin
                m_run = 1'b0; m_pos = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_outputs();
        check_eq("pwm_out",      32'(bus.pwm_out),      32'(m_run && (m_pos < m_duty)));
        check_eq("period_start", 32'(bus.period_start), 32'(m_run && (m_pos == 0)));
        check_eq("duty_active",  32'(bus.duty_active),  32'(m_duty));
        check_eq("busy",         32'(bus.busy),         32'(m_run));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_duty(input int d);
        bus.duty = 24'(d);
        step();
    endtask

    task automatic wait_pos(input int target);
        int k = 0;
        while (!(m_run && m_pos == target) && k < 3 * P) begin
            step();
            k++;
        end
        check_eq("wait_pos", 32'(m_pos), 32'(target));
    endtask

    // count high cycles and length of one complete frame of the DUT waveform
    task automatic measure(input string tag, input int hi_exp);
        int k = 0;
        int hi = 0;
        int len = 0;
        while (!bus.period_start && k < 3 * P) begin
            step();
            k++;
        end
        do begin
            hi += int'(bus.pwm_out);
            len++;
            step();
        end while (!bus.period_start && len < 3 * P);
        check_eq({tag, "_len"}, 32'(len), 32'(P));
        check_eq({tag, "_high"}, 32'(hi), 32'(hi_exp));
    endtask

    int corners[10] = '{0, 1, 2, 59, 60, 61, 99, 100, 101, 150};

    initial begin
        bus.enable = 1'b0;
        bus.duty   = '0;

        // held in reset: everything quiet
        run(3);

        // steady 30-cycle pulse every frame
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        bus.duty   = 24'd30;
        measure("d30_a", exp_high(30));
        measure("d30_b", exp_high(30));

        // duty change mid-frame only takes effect at the next frame
        wait_pos(15);
        bus.duty = 24'd50;
        check_eq("midframe_duty_active", 32'(bus.duty_active), 32'(eff_duty(30)));
        measure("d50", exp_high(50));

        // enable drop at position 40: frame completes, then IDLE
        wait_pos(40);
        bus.enable = 1'b0;
        run(59);
        check_eq("last_cycle_busy", 32'(bus.busy), 32'd1);
        step();
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_pwm", 32'(bus.pwm_out), 32'd0);
        run(20);

        // zero duty, under-range, over-range and over-period requests
        bus.enable = 1'b1;
        set_duty(0);
        measure("d0_a", exp_high(0));
        measure("d0_b", exp_high(0));
        set_duty(5);
        measure("d5", exp_high(5));
        set_duty(90);
        measure("d90", exp_high(90));
        set_duty(150);
        measure("d150_a", exp_high(150));
        measure("d150_b", exp_high(150));

        // asynchronous reset during the HIGH phase
        set_duty(30);
        measure("pre_rst", exp_high(30));
        wait_pos(20);
        #2 rst_n = 1'b0;
        #1;
        m_run = 1'b0; m_pos = 0; m_duty = 0;
        check_eq("rst_pwm", 32'(bus.pwm_out), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_duty_active", 32'(bus.duty_active), 32'd0);
        run(3);
        rst_n = 1'b1;
        step();
        check_eq("restart_start", 32'(bus.period_start), 32'd1);
        measure("post_rst", exp_high(30));

        // randomized duty / enable activity including boundary values
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 4) begin
                bus.duty = 24'(corners[$urandom_range(0, 9)]);
            end else if (r < 7) begin
                bus.duty = 24'($urandom_range(0, 130));
            end else if (r == 7) begin
                bus.enable = ~bus.enable;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_servo.md
PWM_SERVO -- requirements
Module: pwm_servo

Interface
REQ-001 Parameter PERIOD, default 1000000, PWM period in clk_in cycles (20 ms at 50 MHz).
REQ-002 Parameter DUTY_MIN, default 20000, lowest high-time in cycles.
REQ-003 Parameter DUTY_MAX, default 120000, highest high-time in cycles.
REQ-004 clk_in  input  1  single clock, all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  run request; level-sensitive.
REQ-007 duty  input  24  requested high-time in cycles, from the duty generator stage.
REQ-008 pwm_out  output  1  registered servo PWM waveform.
REQ-009 period_start  output  1  one-cycle pulse on the first cycle of each period.
REQ-010 duty_active  output  24  high-time in use for the current period.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, HIGH and LOW, plus a 24-bit cycle counter cnt.
REQ-013 In IDLE with enable=1, the next edge SHALL sample duty into duty_active, clear cnt, pulse period_start and enter HIGH, or enter LOW if the sampled value is 0.
REQ-014 pwm_out SHALL be 1 in exactly duty_active consecutive cycles, beginning on the cycle where period_start=1.
REQ-015 HIGH SHALL go to LOW on the edge where cnt reaches duty_active-1.
REQ-016 cnt SHALL increment every non-IDLE cycle, and a period SHALL last exactly PERIOD cycles.
REQ-017 At cnt=PERIOD-1 with enable=1, the next edge SHALL resample duty, clear cnt, pulse period_start and enter HIGH (LOW if 0).
REQ-018 At cnt=PERIOD-1 with enable=0, the next edge SHALL enter IDLE with pwm_out=0, so the current period always completes.
REQ-019 duty changes during a period SHALL have no effect until the next period boundary.
REQ-020 If duty_active is at least PERIOD, pwm_out SHALL stay 1 for the whole period, and no glitch low SHALL occur at the boundary.
REQ-021 busy SHALL be 1 from the first period_start through the last cycle before IDLE.

Reset
REQ-022 While rst_n=0: state=IDLE, cnt=0, pwm_out=0, period_start=0, duty_active=0, busy=0.
REQ-023 Reset mid-period SHALL abort the period immediately, and after release the block SHALL restart only via REQ-013.

Configuration
REQ-024 With PWM_CLAMP_EN defined, the sampled duty SHALL be clamped into the range [DUTY_MIN, DUTY_MAX] before it is stored in duty_active.
REQ-025 Without PWM_CLAMP_EN, duty SHALL be stored unmodified, and REQ-020 covers the overflow case.

Structure
REQ-026 Package pwm_pkg SHALL hold the state enum and the default PERIOD, DUTY_MIN and DUTY_MAX constants.
REQ-027 The clamp SHALL be the combinational sub-module duty_clamp, which is instantiated only under PWM_CLAMP_EN.

Verification (PERIOD=100, DUTY_MIN=10, DUTY_MAX=60)
REQ-028 Bench: rst_n released, enable=1, duty=30 -> period_start every 100 cycles, pwm_out high for 30 cycles per period.
REQ-029 Bench: duty changed 30->50 at cycle 15 of a period -> that period stays 30 high, the next is 50 high.
REQ-030 Bench: enable dropped at cycle 40 -> period finishes at cycle 99, then IDLE, pwm_out=0, busy=0.
REQ-031 Bench, PWM_CLAMP_EN: duty=5 -> 10 high; duty=90 -> 60 high. Without the macro, duty=150 -> pwm_out held high continuously.
REQ-032 Bench: duty=0 without clamp -> pwm_out stays 0 while period_start still pulses every 100 cycles.
REQ-033 Bench: rst_n low at cycle 20 of a HIGH phase -> pwm_out=0 at once, and after release a fresh period starts per REQ-013.
